// File: rtl/p_emap_line_packer.sv
// p_emap_line_packer
// Packs a stream of vector elements (one element per beat) into
// no_of_units-element memory lines and writes them to the gather unit's
// vector memory. A line write is held off while read_busy is high.
//
// Optional feature macro: P_EMAP_PACKER_DOUBLE_BUFFER_EN
//   defined   : two line buffers; filling continues while a line waits to write
//   undefined : single line buffer (FILL -> PEND -> FILL)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, base_address job start pulse (honoured only in IDLE), first line address
//   in_valid/in_ready   element handshake; in_data element, in_last final element
//   read_busy           gather side reading; blocks line writes
//   write_enable        one-cycle line write strobe
//   write_address/data  line address and packed line (slot 0 at the MSB end)
//   lines_written       lines written in the current job
//   done                one-cycle pulse with the final line write of a job
module p_emap_line_packer #(
    parameter int unsigned element_width = 64,
    parameter int unsigned no_of_units   = 8,
    parameter int unsigned address_width = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [address_width-1:0]               base_address,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [element_width-1:0]               in_data,
    input  logic                                   in_last,
    input  logic                                   read_busy,
    output logic                                   write_enable,
    output logic [address_width-1:0]               write_address,
    output logic [no_of_units*element_width-1:0]   write_data,
    output logic [address_width-1:0]              lines_written,
    output logic                                   done
);

    localparam int unsigned line_width = no_of_units * element_width;
    localparam int unsigned slot_width = (no_of_units > 1) ? $clog2(no_of_units) : 1;
    localparam logic [slot_width-1:0] last_slot = slot_width'(no_of_units - 1);

    // Element index (no_of_units-1-slot) places slot 0 at the MSB end.
    typedef logic [no_of_units-1:0][element_width-1:0] line_t;
    typedef enum logic [1:0] {IDLE, FILL, PEND} state_t;

    state_t                    state_q, state_d;
    logic [slot_width-1:0]     slot_q, slot_d;
    logic [address_width-1:0]  line_addr_q, line_addr_d;

    logic                      in_ready_d, write_enable_d, done_d;
    logic [address_width-1:0]  write_address_d, lines_written_d;
    logic [line_width-1:0]     write_data_d;

`ifdef P_EMAP_PACKER_DOUBLE_BUFFER_EN
    // Two buffers: fill_idx receives beats, wr_idx is the oldest full line.
    line_t       buf_q [2];
    line_t       buf_d [2];
    logic [1:0]  full_q, full_d;
    logic [1:0]  blast_q, blast_d;
    logic        fill_idx_q, fill_idx_d;
    logic        wr_idx_q, wr_idx_d;
    logic        seen_last_q, seen_last_d;

    // Next-state / next-output logic
    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        line_addr_d     = line_addr_q;
        buf_d           = buf_q;
        full_d          = full_q;
        blast_d         = blast_q;
        fill_idx_d      = fill_idx_q;
        wr_idx_d        = wr_idx_q;
        seen_last_d     = seen_last_q;
        write_enable_d  = 1'b0;
        done_d          = 1'b0;
        write_address_d = write_address;
        write_data_d    = write_data;
        lines_written_d = lines_written;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d         = FILL;
                    slot_d          = '0;
                    line_addr_d     = base_address;
                    buf_d           = '{default: '0};
                    full_d          = '0;
                    blast_d         = '0;
                    fill_idx_d      = 1'b0;
                    wr_idx_d        = 1'b0;
                    seen_last_d     = 1'b0;
                    lines_written_d = '0;
                end
            end
            FILL: begin
                // Drain the oldest full line when the gather side is idle.
                if (full_q[wr_idx_q] && !read_busy) begin
                    write_enable_d   = 1'b1;
                    write_address_d  = line_addr_q;
                    write_data_d     = buf_q[wr_idx_q];
                    line_addr_d      = line_addr_q + address_width'(1);
                    lines_written_d  = lines_written + address_width'(1);
                    buf_d[wr_idx_q]  = '0;
                    full_d[wr_idx_q] = 1'b0;
                    wr_idx_d         = ~wr_idx_q;
                    if (blast_q[wr_idx_q]) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                // in_ready guarantees the fill buffer is free and differs from wr_idx.
                if (in_valid && in_ready) begin
                    buf_d[fill_idx_q][last_slot - slot_q] = in_data;
                    slot_d = slot_q + slot_width'(1);
                    if (slot_q == last_slot || in_last) begin
                        full_d[fill_idx_q]  = 1'b1;
                        blast_d[fill_idx_q] = in_last;
                        fill_idx_d          = ~fill_idx_q;
                        slot_d              = '0;
                        seen_last_d         = in_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == FILL) && !seen_last_d && !full_d[fill_idx_d];
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '{default: '0};
            full_q      <= '0;
            blast_q     <= '0;
            fill_idx_q  <= 1'b0;
            wr_idx_q    <= 1'b0;
            seen_last_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            full_q      <= full_d;
            blast_q     <= blast_d;
            fill_idx_q  <= fill_idx_d;
            wr_idx_q    <= wr_idx_d;
            seen_last_q <= seen_last_d;
        end
    end
`else
    line_t  buf_q, buf_d;
    logic   held_last_q, held_last_d;

    // Next-state / next-output logic
    always_comb begin
        state_d         = state_q;
        slot_d          = slot_q;
        line_addr_d     = line_addr_q;
        buf_d           = buf_q;
        held_last_d     = held_last_q;
        write_enable_d  = 1'b0;
        done_d          = 1'b0;
        write_address_d = write_address;
        write_data_d    = write_data;
        lines_written_d = lines_written;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d         = FILL;
                    slot_d          = '0;
                    line_addr_d     = base_address;
                    buf_d           = '0;
                    held_last_d     = 1'b0;
                    lines_written_d = '0;
                end
            end
            FILL: begin
                if (in_valid && in_ready) begin
                    buf_d[last_slot - slot_q] = in_data;
                    slot_d = slot_q + slot_width'(1);
                    if (slot_q == last_slot || in_last) begin
                        held_last_d = in_last;
                        slot_d      = '0;
                        state_d     = PEND;
                    end
                end
            end
            PEND: begin
                if (!read_busy) begin
                    write_enable_d  = 1'b1;
                    write_address_d = line_addr_q;
                    write_data_d    = buf_q;
                    line_addr_d     = line_addr_q + address_width'(1);
                    lines_written_d = lines_written + address_width'(1);
                    buf_d           = '0;
                    slot_d          = '0;
                    if (held_last_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == FILL);
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '0;
            held_last_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            held_last_q <= held_last_d;
        end
    end
`endif

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            slot_q        <= '0;
            line_addr_q   <= '0;
            in_ready      <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_data    <= '0;
            lines_written <= '0;
            done          <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            line_addr_q   <= line_addr_d;
            in_ready      <= in_ready_d;
            write_enable  <= write_enable_d;
            write_address <= write_address_d;
            write_data    <= write_data_d;
            lines_written <= lines_written_d;
            done          <= done_d;
        end
    end

endmodule

// File: tb/tb_p_emap_line_packer.sv
// Scoreboard bench for p_emap_line_packer: stimulus pushes expected line
// writes; a negedge monitor pops and compares every write_enable.
module tb_p_emap_line_packer;

    localparam int unsigned EW = 64;
    localparam int unsigned NU = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = NU * EW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_address;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] in_data;
    logic          in_last;
    logic          read_busy;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [LW-1:0] write_data;
    logic [AW-1:0] lines_written;
    logic          done;

    p_emap_line_packer #(.element_width(EW), .no_of_units(NU), .address_width(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_address(base_address),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .read_busy(read_busy), .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .lines_written(lines_written), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        logic          dn;
        logic [AW-1:0] lw;
    } exp_t;

    exp_t sb[$];
    int   wr_cyc[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line with consecutive values first..first+count-1 from slot 0; rest zero.
    function automatic logic [LW-1:0] mk_line(input int first, input int count);
        logic [LW-1:0] l;
        l = '0;
        for (int s = 0; s < count; s++) l[(NU-s)*EW-1 -: EW] = EW'(first + s);
        return l;
    endfunction

    task automatic push_exp(input logic [AW-1:0] a, input logic [LW-1:0] d,
                            input logic dn, input logic [AW-1:0] lw);
        exp_t e;
        e.addr = a; e.data = d; e.dn = dn; e.lw = lw;
        sb.push_back(e);
    endtask

    // Monitor: compare each write against the scoreboard head
    always @(negedge clk) begin
        if (rst_n) begin
            if (write_enable) begin
                exp_t e;
                checks++;
                wr_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write addr=%h data=%h", write_address, write_data);
                end else begin
                    e = sb.pop_front();
                    if (write_address !== e.addr || write_data !== e.data ||
                        done !== e.dn || lines_written !== e.lw) begin
                        errors++;
                        $display("FAIL line_write got addr=%h done=%b lw=%0d data=%h exp addr=%h done=%b lw=%0d data=%h",
                                 write_address, done, lines_written, write_data,
                                 e.addr, e.dn, e.lw, e.data);
                    end
                end
            end else if (done) begin
                checks++;
                errors++;
                $display("FAIL done_without_write done=%b required 0", done);
            end
        end
    end

    task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_start(input logic [AW-1:0] base);
        start = 1'b1;
        base_address = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present one element and hold it until accepted (bounded).
    task automatic send(input logic [EW-1:0] d, input logic last, output int stalls);
        logic was;
        stalls = 0;
        in_data = d; in_last = last; in_valid = 1'b1;
        forever begin
            was = in_ready;
            @(posedge clk); #1;
            if (was) break;
            stalls++;
            if (stalls > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout data=%0d in_ready=%b required 1", d, in_ready);
                break;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_run(input int first, input int count, input bit last_at_end);
        int st;
        for (int i = 0; i < count; i++)
            send(EW'(first + i), last_at_end && (i == count - 1), st);
    endtask

    // Wait until every expected write is seen, then watch for stray writes.
    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk); n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
            sb.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        rst_n = 1'b0; start = 1'b0; base_address = '0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; read_busy = 1'b0;
        #12;
        chk("rst_in_ready", AW'(in_ready), 0);
        chk("rst_write_enable", AW'(write_enable), 0);
        chk("rst_lines_written", lines_written, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: one full line, last on slot 7
        push_exp(32'h10, {64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8}, 1'b1, 32'd1);
        do_start(32'h10);
        send_run(1, 8, 1'b1);
        drain("t1");
        chk("t1_lines_written_hold", lines_written, 1);

        // 2: eleven elements, partial second line zero-padded
        push_exp(32'h20, mk_line(1, 8), 1'b0, 32'd1);
        push_exp(32'h21, {64'd9, 64'd10, 64'd11, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0}, 1'b1, 32'd2);
        do_start(32'h20);
        send_run(1, 11, 1'b1);
        drain("t2");
        chk("t2_lines_written_hold", lines_written, 2);

        // 3: read_busy holds the completed line for 5 edges
        push_exp(32'h50, mk_line(31, 8), 1'b1, 32'd1);
        do_start(32'h50);
        send_run(31, 7, 1'b0);
        read_busy = 1'b1;
        send(EW'(38), 1'b1, st);
        for (int i = 0; i < 5; i++) begin
            chk("t3_busy_in_ready", AW'(in_ready), 0);
            chk("t3_busy_write_enable", AW'(write_enable), 0);
            @(posedge clk); #1;
        end
        read_busy = 1'b0;
        @(posedge clk); #1;
        chk("t3_write_after_release", AW'(write_enable), 1);
        chk("t3_done_after_release", AW'(done), 1);
        drain("t3");

        // 4: reset mid-line discards it; next job starts clean
        do_start(32'h40);
        send_run(11, 4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_in_ready", AW'(in_ready), 0);
        chk("t4_rst_write_enable", AW'(write_enable), 0);
        chk("t4_rst_done", AW'(done), 0);
        chk("t4_rst_write_address", write_address, 0);
        chk("t4_rst_lines_written", lines_written, 0);
        checks++;
        if (write_data !== '0) begin
            errors++;
            $display("FAIL t4_rst_write_data got=%h exp=0", write_data);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t4_idle_in_ready", AW'(in_ready), 0);
        push_exp(32'h0, mk_line(21, 3), 1'b1, 32'd1);
        do_start(32'h0);
        send_run(21, 3, 1'b1);
        drain("t4");

        // 5: start during a job is ignored
        push_exp(32'h100, mk_line(1, 8), 1'b0, 32'd1);
        push_exp(32'h101, mk_line(9, 4), 1'b1, 32'd2);
        do_start(32'h100);
        send_run(1, 3, 1'b0);
        start = 1'b1; base_address = 32'h200;
        send(EW'(4), 1'b0, st);
        start = 1'b0;
        send_run(5, 8, 1'b1);
        drain("t5");

`ifdef P_EMAP_PACKER_DOUBLE_BUFFER_EN
        // 6: sixteen back-to-back elements never stall
        begin
            int stall_total = 0;
            wr_cyc.delete();
            push_exp(32'h30, mk_line(1, 8), 1'b0, 32'd1);
            push_exp(32'h31, mk_line(9, 8), 1'b1, 32'd2);
            do_start(32'h30);
            for (int i = 0; i < 16; i++) begin
                send(EW'(i + 1), i == 15, st);
                stall_total += st;
            end
            drain("t6");
            chk("t6_stalls", AW'(stall_total), 0);
            chk("t6_write_count", AW'(wr_cyc.size()), 2);
            if (wr_cyc.size() == 2)
                chk("t6_write_spacing", AW'(wr_cyc[1] - wr_cyc[0]), 8);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/p_emap_line_packer.md
# p_emap_line_packer

Write-side companion to the column-gather unit. Accepts a stream of computed vector elements (one `element_width` element per beat) and packs them into `no_of_units`-element memory lines. Drives the gather unit's vector-memory write port (`write_enable` / `write_address` / line data) so results land in the banked layout the gather unit reads back. Writes are deferred while the gather side is reading, which avoids port conflicts.

## Interface
Parameters:
- `element_width`, 64: bits per vector element.
- `no_of_units`, 8: elements per memory line.
- `address_width`, 32: line address width.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse; begins a job. Ignored unless the block is IDLE.
- `base_address`, in, `address_width`: first line address; sampled on accepted `start`.
- `in_valid`, in, 1: element present.
- `in_ready`, out, 1: element accepted when `in_valid & in_ready`.
- `in_data`, in, `element_width`: element value.
- `in_last`, in, 1: qualifies the final element of the job.
- `read_busy`, in, 1: gather side is reading; no write may issue while high.
- `write_enable`, out, 1: one-cycle line write strobe.
- `write_address`, out, `address_width`: line address.
- `write_data`, out, `no_of_units*element_width`: packed line.
- `lines_written`, out, `address_width`: lines written in the current job.
- `done`, out, 1: one-cycle pulse, coincident with the final `write_enable`.

## Operation
- **Packing order:** slot s occupies `write_data[(no_of_units-s)*element_width-1 -: element_width]`. Slot 0 is at the MSB end, matching the gather unit's remainder indexing.
- **IDLE:** `in_ready`=0.
  - On `start`: line_addr ← `base_address`, slot ← 0, line buffer ← 0, `lines_written` ← 0, go to FILL.
- **FILL:** `in_ready`=1.
  - Each accepted beat writes `in_data` into the current slot and increments slot.
  - If the beat fills slot `no_of_units-1`, or carries `in_last`, the line is complete; go to PEND.
  - Unfilled slots remain zero.
- **PEND:** `in_ready`=0.
  - At the first rising edge with `read_busy`=0: register `write_enable`=1, `write_address`=line_addr, `write_data`=buffer.
  - Same edge: line_addr += 1, `lines_written` += 1, buffer ← 0, slot ← 0.
  - If the line held `in_last`: `done`=1 for that cycle, go to IDLE. Otherwise go to FILL.
- `write_enable` and `done` are high for exactly one cycle per event. `write_address` and `write_data` hold their last values otherwise.
- **Arithmetic:** line_addr wraps modulo 2^`address_width`; `lines_written` likewise.
- **Boundary conditions:**
  - `in_last` on slot `no_of_units-1`: exactly one write, no extra empty line.
  - A job always writes at least one line.
  - `start` outside IDLE is ignored; no state change.
  - `in_valid` while `in_ready`=0 has no effect; the source must hold.
- **Reset (any time):** state → IDLE; partial line discarded with no write. `in_ready`, `write_enable`, `done` = 0. `write_address`, `write_data`, `lines_written` = 0.

## Timing
- **Full line:** last element accepted at edge k. `write_enable` is high in the cycle following edge k+1 if `read_busy`=0 at k+1, otherwise following the first edge with `read_busy` low.
- **Single-buffer throughput:** `no_of_units` elements per `no_of_units`+1 cycles when `read_busy` is low.
- `read_busy` is sampled only at edges while PEND. A rise after the write edge does not cancel an issued write.

## Configuration
- Macro: `P_EMAP_PACKER_DOUBLE_BUFFER_EN`.
- **Defined:** two line buffers.
  - A completed line waits in the write buffer while FILL continues into the other buffer.
  - `in_ready` drops only when both buffers are full.
  - Writes issue in fill order.
  - Sustained throughput is `no_of_units` elements per `no_of_units` cycles with `read_busy` low.
  - `done` accompanies the write of the line containing `in_last`.
- **Undefined:** single buffer, behaviour as above.

## Test plan
1. `base_address`=0x10, elements 1..8 back-to-back, `read_busy`=0.
   -> one write at 0x10; slot 0 (MSB) = 1, slot 7 = 8; `done` coincident; `lines_written`=1.
2. 11 elements (1..11), `in_last` on the 11th.
   -> writes at base and base+1; second line has slots 0..2 = 9,10,11 and slots 3..7 = 0; `lines_written`=2.
3. `read_busy` held high 5 cycles from line completion.
   -> `write_enable` stays 0 and `in_ready` stays 0 (single buffer); write issues in the cycle after the first edge with `read_busy` low.
4. `rst_n` pulsed low after 4 accepted elements.
   -> all outputs 0 immediately, no write; a following job with base 0 writes its first line at 0 with clean data.
5. `start` pulsed mid-job with a different `base_address`.
   -> ignored; addresses continue from the original base.
6. With `P_EMAP_PACKER_DOUBLE_BUFFER_EN`: 16 back-to-back elements, `read_busy`=0.
   -> `in_ready` never drops; two writes 8 cycles apart; `done` with the second.
